// File: rtl/vrp_skid_slice.sv
// Two-entry valid/ready skid slice: registers vld/pld downstream and rdy upstream so that
// arbiter and consumer share no combinational path; sustains one transfer per cycle.
module vrp_skid_slice #(
    parameter int PLD_WIDTH   = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vld_s,
    output logic                   rdy_s,
    input  logic [PLD_WIDTH-1:0]   pld_s,
    output logic                   vld_m,
    input  logic                   rdy_m,
    output logic [PLD_WIDTH-1:0]   pld_m,
    output logic [1:0]             occ,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]             state;
    logic [PLD_WIDTH-1:0]   main_reg;
    logic [PLD_WIDTH-1:0]   skid_reg;
    logic [STALL_CNT_W-1:0] cnt;
    logic                   in_hs;
    logic                   out_hs;

    // Outputs come from the state flop only; rst_n gates them so nothing handshakes in reset.
    assign rdy_s     = rst_n & (state != TWO);
    assign vld_m     = rst_n & (state != EMPTY);
    assign pld_m     = rst_n ? main_reg : '0;
    assign occ       = rst_n ? state : 2'd0;
    assign stall_cnt = cnt;

    assign in_hs  = vld_s & rdy_s;
    assign out_hs = vld_m & rdy_m;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_hs) begin
                        main_reg <= pld_s;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (in_hs && out_hs) begin
                        main_reg <= pld_s;
                    end else if (in_hs) begin
                        skid_reg <= pld_s;
                        state    <= TWO;
                    end else if (out_hs) begin
                        state    <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_hs) begin
                        main_reg <= skid_reg;
                        state    <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Saturating count of consecutive stalled cycles; naturally idle while EMPTY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_hs) begin
            cnt <= '0;
        end else if (vld_m && !rdy_m && (cnt != {STALL_CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vrp_skid_slice.sv
// Bench for vrp_skid_slice: per-cycle vector table, hand sequences for streaming and
// stall counting, and a scoreboard checking in-order lossless delivery under random traffic.
module tb_vrp_skid_slice;

    localparam int PW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vld_s;
    logic          rdy_s;
    logic [PW-1:0] pld_s;
    logic          vld_m;
    logic          rdy_m;
    logic [PW-1:0] pld_m;
    logic [1:0]    occ;
    logic [SW-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [PW-1:0] sb_q[$];

    vrp_skid_slice #(.PLD_WIDTH(PW), .STALL_CNT_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_s     (vld_s),
        .rdy_s     (rdy_s),
        .pld_s     (pld_s),
        .vld_m     (vld_m),
        .rdy_m     (rdy_m),
        .pld_m     (pld_m),
        .occ       (occ),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          vld_s;
        logic          rdy_m;
        logic [PW-1:0] pld_s;
        logic          rdy_s;
        logic          vld_m;
        logic [1:0]    occ;
        logic          chk_pld;
        logic [PW-1:0] pld_m;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic r, logic v, logic rm, logic [PW-1:0] p,
                                logic ers, logic evm, logic [1:0] eocc,
                                logic cp, logic [PW-1:0] ep);
        vec_t t;
        t.rst_n = r;   t.vld_s = v;   t.rdy_m = rm;  t.pld_s = p;
        t.rdy_s = ers; t.vld_m = evm; t.occ = eocc;  t.chk_pld = cp; t.pld_m = ep;
        return t;
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Samples on the falling edge, where inputs and outputs are both settled for the next rising edge.
    task automatic monitor();
        logic          prev_stall = 1'b0;
        logic          prev_rst   = 1'b0;
        logic [PW-1:0] prev_pld   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
            end else begin
                if (prev_rst && prev_stall && (pld_m !== prev_pld)) begin
                    failures++;
                    $display("FAIL pld_stable: got 0x%0h expected 0x%0h", pld_m, prev_pld);
                end
                if (occ > 2'd2) begin
                    failures++;
                    $display("FAIL occ_bound: got %0d expected <=2", occ);
                end
                if (vld_s && rdy_s) sb_q.push_back(pld_s);
                if (vld_m && rdy_m) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_extra: got 0x%0h expected no word", pld_m);
                    end else begin
                        chk("sb_order", pld_m, sb_q.pop_front());
                    end
                    pops++;
                end
            end
            prev_rst   = rst_n;
            prev_stall = vld_m & !rdy_m;
            prev_pld   = pld_m;
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic rm, input logic [PW-1:0] p);
        rst_n = r; vld_s = v; rdy_m = rm; pld_s = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        drive(1'b0, 1'b0, 1'b0, '0);
        fork
            monitor();
        join_none

        //        rst vld rdm pld     | rdy_s vld_m occ chk pld_m
        vecs[0]  = mk(0, 1, 0, 32'h11,  0, 0, 2'd0, 1, 32'h0);   // reset, vld_s ignored
        vecs[1]  = mk(0, 1, 0, 32'h11,  0, 0, 2'd0, 1, 32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h11,  0, 0, 2'd0, 1, 32'h0);
        vecs[3]  = mk(1, 0, 0, 32'h0,   1, 0, 2'd0, 1, 32'h0);   // released
        vecs[4]  = mk(1, 1, 0, 32'hA,   1, 1, 2'd1, 1, 32'hA);   // A into main
        vecs[5]  = mk(1, 1, 0, 32'hB,   0, 1, 2'd2, 1, 32'hA);   // B into skid
        vecs[6]  = mk(1, 1, 0, 32'hC,   0, 1, 2'd2, 1, 32'hA);   // C held upstream
        vecs[7]  = mk(1, 1, 1, 32'hC,   1, 1, 2'd1, 1, 32'hB);   // A out, skid->main
        vecs[8]  = mk(1, 1, 1, 32'hC,   1, 1, 2'd1, 1, 32'hC);   // in+out in ONE
        vecs[9]  = mk(1, 0, 1, 32'h0,   1, 0, 2'd0, 0, 32'h0);   // C out, empty
        vecs[10] = mk(1, 1, 0, 32'h21,  1, 1, 2'd1, 1, 32'h21);
        vecs[11] = mk(1, 1, 0, 32'h22,  0, 1, 2'd2, 1, 32'h21);
        vecs[12] = mk(0, 1, 0, 32'h23,  0, 0, 2'd0, 1, 32'h0);   // reset pulse mid-op
        vecs[13] = mk(1, 0, 1, 32'h0,   1, 0, 2'd0, 0, 32'h0);   // nothing stale comes out
        vecs[14] = mk(1, 0, 1, 32'h0,   1, 0, 2'd0, 0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst_n, vecs[i].vld_s, vecs[i].rdy_m, vecs[i].pld_s);
            tick();
            chk($sformatf("vec%0d_rdy_s", i), {31'b0, rdy_s}, {31'b0, vecs[i].rdy_s});
            chk($sformatf("vec%0d_vld_m", i), {31'b0, vld_m}, {31'b0, vecs[i].vld_m});
            chk($sformatf("vec%0d_occ", i),   {30'b0, occ},   {30'b0, vecs[i].occ});
            if (vecs[i].chk_pld) chk($sformatf("vec%0d_pld_m", i), pld_m, vecs[i].pld_m);
        end

        // Streaming: 10 beats, each visible one cycle after acceptance.
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b1, PW'(i));
            chk("t2_rdy_s_pre", {31'b0, rdy_s}, 32'd1);
            tick();
            chk("t2_pld_m", pld_m, PW'(i));
            chk("t2_occ", {30'b0, occ}, 32'd1);
        end
        drive(1'b1, 1'b0, 1'b1, '0);
        tick();
        chk("t2_drained_occ", {30'b0, occ}, 32'd0);
        tick();
        chk("t2_beats", PW'(pops - p0), 32'd10);

        // Stall counter saturates at 15 and clears after an output handshake.
        drive(1'b1, 1'b1, 1'b0, 32'h55);
        tick();
        chk("t4_start", {28'b0, stall_cnt}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1 || k == 14 || k == 15 || k == 16 || k == 20)
                chk($sformatf("t4_stall_k%0d", k), {28'b0, stall_cnt}, (k > 15) ? 32'd15 : 32'(k));
        end
        drive(1'b1, 1'b0, 1'b1, '0);
        tick();
        chk("t4_clear", {28'b0, stall_cnt}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, '0);
        tick(); tick();
        chk("t4_empty_hold", {28'b0, stall_cnt}, 32'd0);

        // Random traffic; scoreboard in the monitor checks every delivered word.
        for (int i = 0; i < 10000; i++) begin
            drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), PW'($urandom));
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, '0);
        tick(); tick(); tick(); tick();
        chk("rand_drained_q", PW'(sb_q.size()), 32'd0);
        chk("rand_drained_occ", {30'b0, occ}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
